// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state encoding and sizing helpers for fb_writer (see FB_WRITER_LINE_PAD_EN in fb_writer.sv)
package fb_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    FULL     = 2'd2
  } fb_state_t;

  // Pixels packed into one framebuffer word.
  function automatic int fb_ppw(input int data_width, input int pixel_width);
    return data_width / pixel_width;
  endfunction

  // The slot counter must be able to hold the value PPW itself.
  function automatic int fb_cnt_width(input int ppw);
    return (ppw < 2) ? 1 : $clog2(ppw + 1);
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs pixels into a word, lowest slot first, and flags completed words
module pixel_packer
  import fb_pkg::*;
#(
  parameter int PIXEL_WIDTH = 1,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   clear,
  input  logic                   pad,
  input  logic [PIXEL_WIDTH-1:0] pixel,
  output logic [DATA_WIDTH-1:0]  word,
  output logic                   word_ready,
  output logic                   partial
);

  localparam int PPW   = fb_ppw(DATA_WIDTH, PIXEL_WIDTH);
  localparam int CNT_W = fb_cnt_width(PPW);

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      base_cnt;
  logic [CNT_W-1:0]      new_cnt;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_next;

  // Build the word as it would look with this pixel inserted; clear restarts at slot 0.
  always_comb begin
    base_cnt  = clear ? '0 : cnt_q;
    new_cnt   = base_cnt + CNT_W'(1);
    word_next = clear ? '0 : word_q;
    for (int k = 0; k < PPW; k++) begin
      if (base_cnt == CNT_W'(k)) begin
        word_next[k*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel;
      end
    end
    word_ready = push && ((new_cnt == CNT_W'(PPW)) || pad);
  end

  assign word    = word_next;
  assign partial = (cnt_q != '0);

  // Slot counter and partial word; a finished word empties the register so padded slots read as zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (word_ready) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (push) begin
      cnt_q  <= new_cnt;
      word_q <= word_next;
    end else if (clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// rtl/fb_writer.sv - pixel stream to framebuffer write port; FB_WRITER_LINE_PAD_EN enables end-of-line word padding
module fb_writer
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_WORDS   = 1 << ADDR_WIDTH,
  parameter int PIXEL_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic                   in_eol,
  input  logic [PIXEL_WIDTH-1:0] in_data,
  output logic                   wr_enable,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   frame_done,
  output logic                   frame_short
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  fb_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, eff_addr;
  logic                  wr_enable_d, frame_done_d, frame_short_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  sof, accept, pad;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_ready, partial;

  assign sof    = in_valid && in_sof;
  assign accept = sof || (in_valid && (state_q == ACTIVE));

`ifdef FB_WRITER_LINE_PAD_EN
  assign pad = in_eol;
`else
  logic unused_eol;
  assign unused_eol = in_eol;
  assign pad        = 1'b0;
`endif

  pixel_packer #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (accept),
    .clear      (sof),
    .pad        (pad),
    .pixel      (in_data),
    .word       (word),
    .word_ready (word_ready),
    .partial    (partial)
  );

  // Next state, address and output values; start-of-frame is resolved before the word write.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    eff_addr      = addr_q;
    wr_enable_d   = 1'b0;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    frame_done_d  = 1'b0;
    frame_short_d = 1'b0;
    if (sof) begin
      frame_short_d = (state_q == ACTIVE) && ((addr_q != '0) || partial);
      eff_addr      = '0;
      addr_d        = '0;
      state_d       = ACTIVE;
    end
    if (word_ready) begin
      wr_enable_d = 1'b1;
      wr_addr_d   = eff_addr;
      wr_data_d   = word;
      if (eff_addr == LAST_ADDR) begin
        frame_done_d = 1'b1;
        state_d      = FULL;
        addr_d       = '0;
      end else begin
        addr_d = eff_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // State register, address counter and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= WAIT_SOF;
      addr_q      <= '0;
      wr_enable   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_enable   <= wr_enable_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      frame_done  <= frame_done_d;
      frame_short <= frame_short_d;
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// tb/tb_fb_writer.sv - self-checking bench for fb_writer against a frame-level reference model
module tb_fb_writer;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int NW  = 16;
  localparam int PW  = 1;
  localparam int PPW = DW / PW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_eol = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          wr_enable;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          frame_short;

  always #5 clk = ~clk;

  fb_writer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_WORDS   (NW),
    .PIXEL_WIDTH (PW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_eol      (in_eol),
    .in_data     (in_data),
    .wr_enable   (wr_enable),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_short (frame_short)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;

  // Reference model: 0 = waiting for frame, 1 = in frame, 2 = frame complete.
  int            m_mode = 0;
  int            m_addr = 0;
  int            m_pix[$];
  logic          exp_en = 0, exp_done = 0, exp_short = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

`ifdef FB_WRITER_LINE_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  function automatic logic [DW-1:0] pack_pixels(input int pix[$]);
    int w = 0;
    for (int k = 0; k < pix.size(); k++) w += pix[k] << (k * PW);
    return DW'(w);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_addr = 0; m_pix.delete();
    exp_en = 0; exp_done = 0; exp_short = 0; exp_addr = '0; exp_data = '0;
  endtask

  task automatic model_pixel(input logic v, input logic s, input logic e, input int d);
    bit take;
    exp_en = 0; exp_done = 0; exp_short = 0;
    take = 0;
    if (v && s) begin
      if (m_mode == 1 && (m_addr != 0 || m_pix.size() != 0)) exp_short = 1;
      m_pix.delete();
      m_addr = 0;
      m_mode = 1;
      take = 1;
    end else if (v && m_mode == 1) begin
      take = 1;
    end
    if (take) begin
      m_pix.push_back(d);
      if (m_pix.size() == PPW || (PAD && e)) begin
        exp_en   = 1;
        exp_addr = AW'(m_addr);
        exp_data = pack_pixels(m_pix);
        m_pix.delete();
        if (m_addr == NW - 1) begin
          exp_done = 1;
          m_mode   = 2;
          m_addr   = 0;
        end else begin
          m_addr++;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    n_tests += 5;
    assert (wr_enable === exp_en) else begin
      n_fail++; $error("FAIL %s wr_enable: got %b expected %b", tag, wr_enable, exp_en);
    end
    assert (wr_addr === exp_addr) else begin
      n_fail++; $error("FAIL %s wr_addr: got %0d expected %0d", tag, wr_addr, exp_addr);
    end
    assert (wr_data === exp_data) else begin
      n_fail++; $error("FAIL %s wr_data: got %h expected %h", tag, wr_data, exp_data);
    end
    assert (frame_done === exp_done) else begin
      n_fail++; $error("FAIL %s frame_done: got %b expected %b", tag, frame_done, exp_done);
    end
    assert (frame_short === exp_short) else begin
      n_fail++; $error("FAIL %s frame_short: got %b expected %b", tag, frame_short, exp_short);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input string tag, input logic v, input logic s, input logic e, input int d);
    in_valid = v; in_sof = s; in_eol = e; in_data = PW'(d);
    model_pixel(v, s, e, d);
    @(posedge clk);
    #1;
    if (wr_enable === 1'b1) wr_seen++;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset_n = 0; in_valid = 0; in_sof = 0; in_eol = 0; in_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    reset_n = 1;
  endtask

  initial begin
    int first_word[8];
    int gap;
    first_word = '{1, 0, 1, 1, 0, 0, 0, 1};

    // Reset, then pixels without start-of-frame are discarded.
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 20; i++) step("wait_sof", 1, 0, 0, $urandom_range(0, 1));

    // First word 8'h8D at address 0.
    for (int i = 0; i < 8; i++) step("first_word", 1, (i == 0), 0, first_word[i]);
    n_tests++;
    assert (wr_enable === 1'b1 && wr_addr === 4'd0 && wr_data === 8'h8D) else begin
      n_fail++; $error("FAIL first_word_direct: got en=%b addr=%0d data=%h expected en=1 addr=0 data=8d",
                       wr_enable, wr_addr, wr_data);
    end
    step("first_word_idle", 0, 0, 0, 0);

    // Full frame of ones, extra pixels ignored, then restart at address 0.
    wr_seen = 0;
    for (int i = 0; i < NW * PPW; i++) step("full_frame", 1, (i == 0), 0, 1);
    n_tests++;
    assert (frame_done === 1'b1 && wr_addr === 4'd15) else begin
      n_fail++; $error("FAIL frame_done_last: got done=%b addr=%0d expected done=1 addr=15", frame_done, wr_addr);
    end
    for (int i = 0; i < 16; i++) step("full_extra", 1, 0, 0, 1);
    n_tests++;
    assert (wr_seen === NW) else begin
      n_fail++; $error("FAIL full_write_count: got %0d expected %0d", wr_seen, NW);
    end
    for (int i = 0; i < PPW; i++) step("restart", 1, (i == 0), 0, $urandom_range(0, 1));
    n_tests++;
    assert (wr_enable === 1'b1 && wr_addr === 4'd0) else begin
      n_fail++; $error("FAIL restart_addr: got en=%b addr=%0d expected en=1 addr=0", wr_enable, wr_addr);
    end

    // Short frame: two words plus three pixels, then a new start-of-frame.
    for (int i = 0; i < 2 * PPW + 3; i++) step("short_pre", 1, (i == 0), 0, $urandom_range(0, 1));
    step("short_sof", 1, 1, 0, 1);
    n_tests++;
    assert (frame_short === 1'b1 && wr_enable === 1'b0) else begin
      n_fail++; $error("FAIL short_pulse: got short=%b en=%b expected short=1 en=0", frame_short, wr_enable);
    end
    for (int i = 1; i < PPW; i++) step("short_after", 1, 0, 0, $urandom_range(0, 1));

    // Line end after three ones.
    wr_seen = 0;
    step("line_pad", 1, 1, 0, 1);
    step("line_pad", 1, 0, 0, 1);
    step("line_pad", 1, 0, 1, 1);
    n_tests++;
    assert (wr_seen === (PAD ? 1 : 0)) else begin
      n_fail++; $error("FAIL line_pad_writes: got %0d expected %0d", wr_seen, PAD ? 1 : 0);
    end
    for (int i = 0; i < PPW; i++) step("line_pad_next", 1, 0, 0, $urandom_range(0, 1));

    // Gapped input: same word regardless of idle cycles.
    for (int i = 0; i < PPW; i++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step("gapped_idle", 0, 0, 0, $urandom_range(0, 1));
      step("gapped", 1, (i == 0), 0, first_word[i]);
    end
    n_tests++;
    assert (wr_enable === 1'b1 && wr_addr === 4'd0 && wr_data === 8'h8D) else begin
      n_fail++; $error("FAIL gapped_word: got en=%b addr=%0d data=%h expected en=1 addr=0 data=8d",
                       wr_enable, wr_addr, wr_data);
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < 13; i++) step("mid_pre", 1, (i == 0), 0, 1);
    do_reset();
    step("mid_post", 1, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step("random", ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
# fb_writer

Packs an incoming pixel stream into framebuffer words and drives the write port of the dual-port framebuffer RAM. It sits directly upstream of the RAM: the video-capture front end hands it one pixel per qualified cycle, and it emits `wr_enable`/`wr_addr`/`wr_data` with an auto-incrementing address that restarts on every start-of-frame. The RAM's read side, in its own clock domain, scans the stored frame out independently.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: RAM address width; must equal the RAM instance's `ADDR_WIDTH`.
- `DATA_WIDTH`, 8: RAM word width.
- `NUM_WORDS`, `1 << ADDR_WIDTH`: words per frame. Legal range is 1 to `2**ADDR_WIDTH`.
- `PIXEL_WIDTH`, 1: bits per pixel. `DATA_WIDTH % PIXEL_WIDTH == 0`.

Ports. One clock; reset is synchronous and active-low.
- `clk`, in, 1: the only clock. It also drives the RAM's `wr_clk`.
- `reset_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: a pixel is presented this cycle. There is no backpressure.
- `in_sof`, in, 1: qualified by `in_valid`; this pixel is the first pixel of a frame.
- `in_eol`, in, 1: qualified by `in_valid`; this pixel is the last pixel of a line.
- `in_data`, in, `PIXEL_WIDTH`: pixel value.
- `wr_enable`, out, 1: RAM write strobe.
- `wr_addr`, out, `ADDR_WIDTH`: RAM write address.
- `wr_data`, out, `DATA_WIDTH`: packed word.
- `frame_done`, out, 1: one-cycle pulse, asserted together with the write to address `NUM_WORDS-1`.
- `frame_short`, out, 1: one-cycle pulse, asserted when a new start-of-frame cuts off a frame that had not completed.

## Operation
- `PPW = DATA_WIDTH / PIXEL_WIDTH` is the number of pixels per word.
- A pixel is accepted when `in_valid` is high and the state is ACTIVE, or when it carries `in_sof`.
- Packing order:
  - The first accepted pixel of a word occupies bits `[PIXEL_WIDTH-1:0]`.
  - Pixel k of a word occupies bits `[(k+1)*PIXEL_WIDTH-1 : k*PIXEL_WIDTH]`.
- States:
  - **WAIT_SOF** (reset state): every pixel is discarded. `in_valid && in_sof` moves to ACTIVE and makes that pixel slot 0 of word 0.
  - **ACTIVE**:
    - Each accepted pixel is appended to the word being packed.
    - When the word reaches `PPW` pixels, it is written to the current address, the address increments, and the pixel count clears.
    - After the write to `NUM_WORDS-1` the state moves to FULL.
  - **FULL**: pixels are discarded and no writes occur. `in_valid && in_sof` restarts the frame exactly as from WAIT_SOF.
- `in_sof` while ACTIVE (start-of-frame takes priority over everything else):
  - A partially packed word is dropped and never written.
  - If the address or pixel count is nonzero, `frame_short` pulses.
  - The address resets to 0, and the `in_sof` pixel becomes slot 0 of word 0.
- The address never exceeds `NUM_WORDS-1`; there is no wrap-around within a frame.
- `in_eol` is ignored unless `FB_WRITER_LINE_PAD_EN` is defined.
- Reset mid-operation: the partial word and address are discarded, all outputs clear, and the state returns to WAIT_SOF. RAM contents are not touched.

## Timing
- All outputs are registered.
- Reset values: `wr_enable=0`, `wr_addr=0`, `wr_data=0`, `frame_done=0`, `frame_short=0`.
- Latency: if the pixel that completes a word is accepted in cycle N, then `wr_enable` is high in cycle N+1 with that word's `wr_addr` and `wr_data`.
- `wr_enable` is high for exactly one cycle per word.
- `wr_addr` and `wr_data` hold their last values while `wr_enable` is low.
- Throughput is one pixel per cycle sustained. Gaps in `in_valid` are allowed anywhere.
- `frame_short` pulses in cycle N+1 after an `in_sof` pixel accepted in cycle N.
- `frame_done` pulses in the same cycle as the final write.

## Configuration
- `FB_WRITER_LINE_PAD_EN` defined:
  - If an accepted pixel carries `in_eol` and the word is still partial after that pixel is appended, the word is written immediately.
  - Unfilled upper slots of that word are zero.
  - The next pixel starts a new word at the next address, so every line begins word-aligned.
  - `in_eol` on a pixel that completes a word causes exactly one write, not two.
  - `in_sof` and `in_eol` on the same pixel: the start-of-frame is processed first, then the pad write goes to address 0.
- Not defined: the `in_eol` port is present but ignored. Lines pack contiguously across line boundaries.

## Structure
- The shared package `fb_pkg` holds:
  - the state encoding (WAIT_SOF, ACTIVE, FULL);
  - the `PPW` derivation function;
  - the bit width of the pixel-count register.
- `fb_writer` contains the state machine, the address counter and the output registers.
- One sub-module, `pixel_packer`:
  - holds the shift/insert register and the slot counter;
  - inputs: `push`, `clear`, `pad`;
  - outputs: `word`, `word_ready`.

## Test plan
Unless stated, use `DATA_WIDTH=8`, `PIXEL_WIDTH=1`, `ADDR_WIDTH=4` (`NUM_WORDS=16`).
- **Reset and WAIT_SOF:** hold `reset_n=0` for 3 cycles, then send 20 pixels without `in_sof` → all outputs stay 0 and no `wr_enable`.
- **First word:** `in_sof` on the first of pixels 1,0,1,1,0,0,0,1 → `wr_enable` for one cycle after the 8th pixel, `wr_addr=0`, `wr_data=8'h8D`.
- **Full frame:** 128 pixels of value 1 starting with `in_sof` → 16 writes of `8'hFF` to addresses 0 through 15, `frame_done` with address 15. Then 16 more pixels → no writes. Then `in_sof` → the next write goes to address 0.
- **Short frame:** after 2 full words plus 3 pixels, send an `in_sof` pixel → `frame_short` pulses, the partial word is never written, and the next write goes to `wr_addr=0`.
- **Line pad:** pixels 1,1,1 with `in_eol` on the third. With `FB_WRITER_LINE_PAD_EN` → write `8'h07` at address 0, and the next word goes to address 1. Without the macro → no write.
- **Gapped input:** 8 pixels with random `in_valid` gaps of up to 5 cycles → the same word and address as with contiguous input, and the write appears exactly one cycle after the 8th accepted pixel.
